// File: rtl/sram_1r1w_bank_model_if.sv
// ---------------------------------------------------------------------------
// sram_1r1w_bank_model_if
//
// Bundles one t1 bank port of the algorithmic memory: the write port (A),
// the read port (B), the single-bit error-injection port and the status
// outputs returned by the bank model.
//
// Signal summary
//   writeA / addrA / bwA / dinA : write strobe, row, per-bit enable, data
//   readB  / addrB              : read strobe, row
//   doutB  / doutB_vld          : read data and its one-cycle fresh marker
//   ready                       : bank finished its init sweep
//   inj_vld / inj_adr / inj_bit : flip one stored bit
//
// Handshake semantics: the bank has no back-pressure. While ready is high,
// every cycle with writeA, readB or inj_vld high is one accepted operation,
// consumed on that rising edge. While ready is low those strobes are
// dropped. doutB_vld is high for exactly one cycle per accepted read, a
// fixed number of cycles after that read, and doutB is meaningful only in
// that cycle (it merely holds its last value otherwise).
//
// Modports
//   master : the driving memory top
//   slave  : the bank model
// ---------------------------------------------------------------------------
interface sram_1r1w_bank_model_if #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned BITADDR = 8,
    parameter int unsigned BITWDTH = 7
) ();

    logic               writeA;
    logic [BITADDR-1:0] addrA;
    logic [WIDTH-1:0]   bwA;
    logic [WIDTH-1:0]   dinA;
    logic               readB;
    logic [BITADDR-1:0] addrB;
    logic [WIDTH-1:0]   doutB;
    logic               doutB_vld;
    logic               ready;
    logic               inj_vld;
    logic [BITADDR-1:0] inj_adr;
    logic [BITWDTH-1:0] inj_bit;

    modport master (
        output writeA, addrA, bwA, dinA,
        output readB, addrB,
        output inj_vld, inj_adr, inj_bit,
        input  doutB, doutB_vld, ready
    );

    modport slave (
        input  writeA, addrA, bwA, dinA,
        input  readB, addrB,
        input  inj_vld, inj_adr, inj_bit,
        output doutB, doutB_vld, ready
    );

endinterface

// File: rtl/sram_1r1w_bank_model.sv
// ---------------------------------------------------------------------------
// sram_1r1w_bank_model
//
// Behavioural single-bank 1R1W SRAM that answers one t1 bank port. It stores
// the physical word, merges writes under a bit mask, returns reads through a
// fixed SRAM_DELAY-stage pipeline, sweeps INITVAL into every row after reset
// and can flip one stored bit per cycle to exercise upstream ECC/parity.
//
// Parameters
//   WIDTH      : physical word width
//   NUMADDR    : number of rows (NUMADDR <= 2**BITADDR)
//   BITADDR    : row address width
//   SRAM_DELAY : read latency in cycles, legal range 1..8
//   INITVAL    : value written to every row by the init sweep
//   BITWDTH    : bit-index width for injection (2**BITWDTH >= WIDTH)
//
// Ports
//   clk         : clock, all state on the rising edge
//   rst         : asynchronous active-low reset
//   bus         : slave side of sram_1r1w_bank_model_if
//   dbg_state_o : current FSM state (0 = INIT sweep, 1 = RUN)
// ---------------------------------------------------------------------------
module sram_1r1w_bank_model #(
    parameter int unsigned       WIDTH      = 128,
    parameter int unsigned       NUMADDR    = 256,
    parameter int unsigned       BITADDR    = 8,
    parameter int unsigned       SRAM_DELAY = 2,
    parameter logic [WIDTH-1:0]  INITVAL    = '0,
    parameter int unsigned       BITWDTH    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_1r1w_bank_model_if.slave bus,
    output logic                 dbg_state_o
);

    // Internal row index is just wide enough for NUMADDR rows; the port
    // address is range-checked first and then narrowed to this width.
    localparam int unsigned IDXW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
    typedef logic [IDXW-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NUMADDR - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    idx_t              cnt_q, cnt_d;
    logic              sweep_we;

    logic [WIDTH-1:0]  mem_q [NUMADDR];

    logic [SRAM_DELAY-1:0] pipe_vld_q, pipe_vld_d;
    logic [WIDTH-1:0]      pipe_dat_q [SRAM_DELAY];
    logic [WIDTH-1:0]      pipe_dat_d [SRAM_DELAY];

    // ------------------------------------------------------------------
    // Port decode
    // ------------------------------------------------------------------
    logic              run;
    logic              wr_en;
    logic              rd_take;
    logic              rd_hit;
    logic              inj_en;
    idx_t              wr_idx;
    idx_t              rd_idx;
    idx_t              inj_idx;
    logic [WIDTH-1:0]  wr_row;
    logic [WIDTH-1:0]  inj_base;
    logic [WIDTH-1:0]  inj_mask;
    logic [WIDTH-1:0]  inj_row;
    logic [WIDTH-1:0]  rd_data;

    assign run     = (state_q == ST_RUN);
    assign wr_idx  = idx_t'(bus.addrA);
    assign rd_idx  = idx_t'(bus.addrB);
    assign inj_idx = idx_t'(bus.inj_adr);

    // Out-of-range rows and bit indices are rejected here so that the
    // narrowed index never aliases onto a real row.
    assign wr_en   = run && bus.writeA && (32'(bus.addrA) < NUMADDR);
    assign rd_take = run && bus.readB;
    assign rd_hit  = rd_take && (32'(bus.addrB) < NUMADDR);
    assign inj_en  = run && bus.inj_vld && (32'(bus.inj_adr) < NUMADDR)
                     && (32'(bus.inj_bit) < WIDTH);

    always_comb begin
        wr_row   = (mem_q[wr_idx] & ~bus.bwA) | (bus.dinA & bus.bwA);
        // Injection acts on the row as it will be after a same-cycle write,
        // so a write cannot silently erase the injected error.
        inj_base = (wr_en && (wr_idx == inj_idx)) ? wr_row : mem_q[inj_idx];
        inj_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bus.inj_bit;
        inj_row  = inj_base ^ inj_mask;
        // A read of a nonexistent row still produces a valid beat of zeros.
        rd_data  = '0;
        if (rd_hit) begin
            rd_data = mem_q[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // FSM: INIT sweeps one row per cycle, RUN serves traffic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                sweep_we = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + idx_t'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. No reset: contents are rebuilt by the sweep. Later writes in
    // this block win, giving the order sweep < write < injection. Reads use
    // mem_q before the edge, which is what makes same-row read/write return
    // the old data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[cnt_q] <= INITVAL;
        end
        if (wr_en) begin
            mem_q[wr_idx] <= wr_row;
        end
        if (inj_en) begin
            mem_q[inj_idx] <= inj_row;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Each stage only loads data when a valid beat enters it,
    // so the last stage (doutB) keeps the most recent read result between
    // reads while its valid bit drops.
    // ------------------------------------------------------------------
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = rd_take;
        pipe_dat_d[0] = rd_take ? rd_data : pipe_dat_q[0];
        for (int i = 1; i < int'(SRAM_DELAY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_vld_q[i-1] ? pipe_dat_q[i-1] : pipe_dat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(SRAM_DELAY); i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < int'(SRAM_DELAY); i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers
    // ------------------------------------------------------------------
    assign bus.doutB     = pipe_dat_q[SRAM_DELAY-1];
    assign bus.doutB_vld = pipe_vld_q[SRAM_DELAY-1];
    assign bus.ready     = run;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_1r1w_bank_model.sv
// ---------------------------------------------------------------------------
// tb_sram_1r1w_bank_model
//
// Three bank models share one set of stimulus signals:
//   u_dut2 : WIDTH 128, NUMADDR 256, SRAM_DELAY 2, INITVAL 0
//   u_dut1 : WIDTH 100, NUMADDR 16,  SRAM_DELAY 1, INITVAL 0xDEADBEEF
//   u_dut4 : WIDTH 100, NUMADDR 16,  SRAM_DELAY 4, INITVAL 0xDEADBEEF
// The small instances see rows >= 16 and bit indices >= 100 as out of range.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_sram_1r1w_bank_model;

    localparam logic [127:0] S_INIT = 128'hDEAD_BEEF;

    logic         clk;
    logic         rst;
    logic         writeA;
    logic [7:0]   addrA;
    logic [127:0] bwA;
    logic [127:0] dinA;
    logic         readB;
    logic [7:0]   addrB;
    logic         inj_vld;
    logic [7:0]   inj_adr;
    logic [6:0]   inj_bit;
    logic         dbg2, dbg1, dbg4;

    int           checks;
    int           errors;
    int           edges;
    logic         saw_vld;

    sram_1r1w_bank_model_if #(.WIDTH(128), .BITADDR(8), .BITWDTH(7)) bus2 ();
    sram_1r1w_bank_model_if #(.WIDTH(100), .BITADDR(8), .BITWDTH(7)) bus1 ();
    sram_1r1w_bank_model_if #(.WIDTH(100), .BITADDR(8), .BITWDTH(7)) bus4 ();

    assign bus2.writeA  = writeA;
    assign bus2.addrA   = addrA;
    assign bus2.bwA     = bwA;
    assign bus2.dinA    = dinA;
    assign bus2.readB   = readB;
    assign bus2.addrB   = addrB;
    assign bus2.inj_vld = inj_vld;
    assign bus2.inj_adr = inj_adr;
    assign bus2.inj_bit = inj_bit;

    assign bus1.writeA  = writeA;
    assign bus1.addrA   = addrA;
    assign bus1.bwA     = bwA[99:0];
    assign bus1.dinA    = dinA[99:0];
    assign bus1.readB   = readB;
    assign bus1.addrB   = addrB;
    assign bus1.inj_vld = inj_vld;
    assign bus1.inj_adr = inj_adr;
    assign bus1.inj_bit = inj_bit;

    assign bus4.writeA  = writeA;
    assign bus4.addrA   = addrA;
    assign bus4.bwA     = bwA[99:0];
    assign bus4.dinA    = dinA[99:0];
    assign bus4.readB   = readB;
    assign bus4.addrB   = addrB;
    assign bus4.inj_vld = inj_vld;
    assign bus4.inj_adr = inj_adr;
    assign bus4.inj_bit = inj_bit;

    sram_1r1w_bank_model #(
        .WIDTH(128), .NUMADDR(256), .BITADDR(8), .SRAM_DELAY(2),
        .INITVAL(128'h0), .BITWDTH(7)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state_o(dbg2));

    sram_1r1w_bank_model #(
        .WIDTH(100), .NUMADDR(16), .BITADDR(8), .SRAM_DELAY(1),
        .INITVAL(100'hDEAD_BEEF), .BITWDTH(7)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state_o(dbg1));

    sram_1r1w_bank_model #(
        .WIDTH(100), .NUMADDR(16), .BITADDR(8), .SRAM_DELAY(4),
        .INITVAL(100'hDEAD_BEEF), .BITWDTH(7)
    ) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state_o(dbg4));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeA  = 1'b0;
        addrA   = '0;
        bwA     = '0;
        dinA    = '0;
        readB   = 1'b0;
        addrB   = '0;
        inj_vld = 1'b0;
        inj_adr = '0;
        inj_bit = '0;
    endtask

    task automatic write_row(input logic [7:0] a, input logic [127:0] d, input logic [127:0] bw);
        writeA = 1'b1;
        addrA  = a;
        dinA   = d;
        bwA    = bw;
        tick();
        idle();
    endtask

    // Read on the delay-2 bank: vld must be 0, then 1 with data, then 0.
    task automatic read_main(input string tag, input logic [7:0] a, input logic [127:0] exp);
        readB = 1'b1;
        addrB = a;
        tick();
        idle();
        check({tag, " vld early"}, bus2.doutB_vld, 128'd0);
        tick();
        check({tag, " vld"}, bus2.doutB_vld, 128'd1);
        check({tag, " data"}, bus2.doutB, exp);
        tick();
        check({tag, " vld pulse"}, bus2.doutB_vld, 128'd0);
    endtask

    // Read on the small banks: delay 1 checked after one edge, delay 4 after four.
    task automatic read_small(input string tag, input logic [7:0] a,
                              input logic [127:0] exp1, input logic [127:0] exp4);
        readB = 1'b1;
        addrB = a;
        tick();
        idle();
        check({tag, " d1 vld"}, bus1.doutB_vld, 128'd1);
        check({tag, " d1 data"}, bus1.doutB, exp1);
        tick();
        tick();
        check({tag, " d4 vld early"}, bus4.doutB_vld, 128'd0);
        tick();
        check({tag, " d4 vld"}, bus4.doutB_vld, 128'd1);
        check({tag, " d4 data"}, bus4.doutB, exp4);
        tick();
    endtask

    function automatic logic [127:0] pat(input int i);
        return (128'd1 << 92) | 128'(3 * i + 1);
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst doutB", bus2.doutB, 128'd0);
        check("rst vld", bus2.doutB_vld, 128'd0);
        check("rst ready", bus2.ready, 128'd0);
        check("rst state", dbg2, 128'd0);
        check("rst d4 doutB", bus4.doutB, 128'd0);

        // Init sweep; traffic during the sweep must be ignored
        rst = 1'b1;
        edges = 0;
        saw_vld = 1'b0;
        while (bus2.ready !== 1'b1 && edges < 400) begin
            idle();
            if (edges == 99) begin
                writeA = 1'b1; addrA = 8'd40; dinA = '1; bwA = '1;
                readB  = 1'b1; addrB = 8'd40;
            end
            tick();
            edges++;
            if (bus2.doutB_vld) saw_vld = 1'b1;
        end
        idle();
        check("ready latency", 128'(edges), 128'd256);
        check("ready high", bus2.ready, 128'd1);
        check("state run", dbg2, 128'd1);
        check("no vld in init", saw_vld, 128'd0);
        check("small ready", {bus1.ready, bus4.ready}, 128'd3);

        // Rows after sweep
        read_main("init row0", 8'd0, 128'd0);
        read_main("init row128", 8'd128, 128'd0);
        read_main("init row255", 8'd255, 128'd0);
        read_main("init-time write ignored", 8'd40, 128'd0);

        // Bit-write mask
        write_row(8'd5, '1, 128'hFF);
        read_main("bw low8", 8'd5, 128'hFF);
        write_row(8'd5, 128'd0, 128'd0);
        read_main("bw zero", 8'd5, 128'hFF);
        write_row(8'd5, 128'd0, 128'hF0F0);
        read_main("bw mixed", 8'd5, 128'h0F);

        // Read-before-write on the same row
        write_row(8'd9, 128'h3C, '1);
        writeA = 1'b1; addrA = 8'd9; dinA = 128'hA5; bwA = '1;
        readB  = 1'b1; addrB = 8'd9;
        tick();
        writeA = 1'b0;
        tick();
        readB = 1'b0;
        check("rbw old vld", bus2.doutB_vld, 128'd1);
        check("rbw old data", bus2.doutB, 128'h3C);
        tick();
        check("rbw new vld", bus2.doutB_vld, 128'd1);
        check("rbw new data", bus2.doutB, 128'hA5);
        tick();
        check("rbw vld off", bus2.doutB_vld, 128'd0);
        check("rbw hold", bus2.doutB, 128'hA5);

        // Injection merged after a same-cycle write
        write_row(8'd7, 128'hFF, '1);
        writeA  = 1'b1; addrA = 8'd7; dinA = 128'd0; bwA = '1;
        inj_vld = 1'b1; inj_adr = 8'd7; inj_bit = 7'd3;
        readB   = 1'b1; addrB = 8'd7;
        tick();
        idle();
        tick();
        check("inj pre-edge data", bus2.doutB, 128'hFF);
        tick();
        read_main("inj after write", 8'd7, 128'h08);
        inj_vld = 1'b1; inj_adr = 8'd7; inj_bit = 7'd127;
        tick();
        idle();
        read_main("inj msb", 8'd7, (128'd1 << 127) | 128'h08);

        // Out-of-range injection / write on the 16-row, 100-bit banks
        inj_vld = 1'b1; inj_adr = 8'd20; inj_bit = 7'd0;
        tick();
        inj_adr = 8'd4; inj_bit = 7'd110;
        tick();
        inj_bit = 7'd99;
        tick();
        idle();
        write_row(8'd20, '1, '1);
        read_small("small row4", 8'd4, S_INIT ^ (128'd1 << 99), S_INIT ^ (128'd1 << 99));
        read_small("small row8", 8'd8, S_INIT, S_INIT);
        read_small("small oob read", 8'd40, 128'd0, 128'd0);

        // Continuous reads of rows 0..15 on all three banks
        for (int i = 0; i < 16; i++) begin
            write_row(8'(i), pat(i), '1);
        end
        for (int c = 0; c < 20; c++) begin
            readB = (c < 16);
            addrB = 8'(c);
            tick();
            if (c < 16) begin
                check($sformatf("strm d1 vld c%0d", c), bus1.doutB_vld, 128'd1);
                check($sformatf("strm d1 data c%0d", c), bus1.doutB, pat(c));
            end else begin
                check($sformatf("strm d1 idle c%0d", c), bus1.doutB_vld, 128'd0);
                check($sformatf("strm d1 hold c%0d", c), bus1.doutB, pat(15));
            end
            if (c >= 3 && c <= 18) begin
                check($sformatf("strm d4 vld c%0d", c), bus4.doutB_vld, 128'd1);
                check($sformatf("strm d4 data c%0d", c), bus4.doutB, pat(c - 3));
            end else begin
                check($sformatf("strm d4 idle c%0d", c), bus4.doutB_vld, 128'd0);
            end
            if (c >= 1 && c <= 16) begin
                check($sformatf("strm d2 vld c%0d", c), bus2.doutB_vld, 128'd1);
                check($sformatf("strm d2 data c%0d", c), bus2.doutB, pat(c - 1));
            end else begin
                check($sformatf("strm d2 idle c%0d", c), bus2.doutB_vld, 128'd0);
            end
        end
        idle();
        check("strm d4 hold", bus4.doutB, pat(15));
        check("strm d2 hold", bus2.doutB, pat(15));

        // Reset with reads in flight
        write_row(8'd100, 128'hBEEF, '1);
        readB = 1'b1; addrB = 8'd2;
        tick();
        addrB = 8'd3;
        tick();
        idle();
        rst = 1'b0;
        #1;
        check("mid rst d2 vld", bus2.doutB_vld, 128'd0);
        check("mid rst d2 doutB", bus2.doutB, 128'd0);
        check("mid rst d4 vld", bus4.doutB_vld, 128'd0);
        check("mid rst d4 doutB", bus4.doutB, 128'd0);
        check("mid rst ready", bus2.ready, 128'd0);
        check("mid rst state", dbg2, 128'd0);
        saw_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus1.doutB_vld || bus2.doutB_vld || bus4.doutB_vld) saw_vld = 1'b1;
        end
        rst = 1'b1;
        edges = 0;
        while (bus2.ready !== 1'b1 && edges < 400) begin
            tick();
            edges++;
            if (bus1.doutB_vld || bus2.doutB_vld || bus4.doutB_vld) saw_vld = 1'b1;
        end
        check("re-sweep latency", 128'(edges), 128'd256);
        check("in-flight reads dropped", saw_vld, 128'd0);
        read_main("re-init row100", 8'd100, 128'd0);
        read_main("re-init row2", 8'd2, 128'd0);
        read_small("re-init small row2", 8'd2, S_INIT, S_INIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_bank_model.md
# sram_1r1w_bank_model

Single-bank, one-read-port/one-write-port SRAM responder that sits on the far side of one t1 bank interface of an algorithmic memory top. The top drives writeA/addrA/bwA/dinA and readB/addrB; this block stores the physical word, applies the bit-write mask, and returns doutB after a fixed pipeline latency of SRAM_DELAY cycles. It also contains a post-reset initialisation sweep and a single-bit error-injection port so the ECC/parity paths upstream can be exercised.

## Interface
- WIDTH, 128, physical word width (equals PHYWDTH of the driving top)
- NUMADDR, 256, number of rows
- BITADDR, 8, row address width
- SRAM_DELAY, 2, read latency in cycles, legal range 1..8
- INITVAL, 0, value written to every row by the init sweep
- BITWDTH, 7, bit-index width for injection, 2^BITWDTH >= WIDTH
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- writeA  input  1  write strobe
- addrA  input  BITADDR  write row
- bwA  input  WIDTH  per-bit write enable, 1 = update bit
- dinA  input  WIDTH  write data
- readB  input  1  read strobe
- addrB  input  BITADDR  read row
- doutB  output  WIDTH  read data, SRAM_DELAY cycles after readB
- doutB_vld  output  1  marks the cycle doutB carries a fresh read
- ready  output  1  init sweep complete, port accepts traffic
- inj_vld  input  1  flip one stored bit this cycle
- inj_adr  input  BITADDR  row to corrupt
- inj_bit  input  BITWDTH  bit index to flip

## Operation
- States: INIT, RUN. rst low forces INIT with sweep counter = 0.
- INIT: one row per cycle, mem[cnt] <= INITVAL, cnt increments; after row NUMADDR-1 written, next cycle enters RUN and ready goes high. INIT lasts exactly NUMADDR cycles after rst release.
- INIT: writeA, readB, inj_vld ignored; no read enters the pipeline, doutB_vld stays 0.
- RUN write: if writeA and addrA < NUMADDR, mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA). addrA >= NUMADDR: write dropped.
- RUN read: if readB, sample mem[addrB] (pre-edge contents) into pipeline stage 0; addrB >= NUMADDR samples 0.
- Read/write same row, same cycle: read returns old data (read-before-write).
- Injection (RUN only): inj_vld and inj_adr < NUMADDR and inj_bit < WIDTH flips that bit of the row after any same-cycle write merge; otherwise ignored. Same-cycle read of that row still returns pre-edge data.
- Pipeline: SRAM_DELAY stages of {vld, data}. doutB/doutB_vld are the last stage. When no read arrives, doutB holds its last value; doutB_vld is 0.
- rst asserted mid-operation: pipeline cleared, in-flight reads discarded, ready drops, sweep restarts from row 0 (contents re-initialised).

## Timing
- Reset values: doutB = 0, doutB_vld = 0, ready = 0, state = INIT, cnt = 0.
- ready rises on the edge NUMADDR cycles after the first rising clk edge with rst high.
- Read issued at edge N: doutB/doutB_vld valid after edge N+SRAM_DELAY-1+1, i.e. observable in cycle N+SRAM_DELAY.
- Write at edge N visible to a read issued at edge N+1.
- Back-to-back reads every cycle supported; throughput 1 read + 1 write + 1 injection per cycle.
- No combinational path from any input to any output.

## Test plan
- Reset release, NUMADDR=256: ready low for 256 cycles, then high; read rows 0, 128, 255 -> doutB = INITVAL, doutB_vld pulses exactly 2 cycles after each readB.
- Write row 5 dinA=all-ones, bwA=0x00FF..(low 8 bits) over INITVAL 0 -> read row 5 returns 0x..00FF; second write bwA=0, dinA=0 -> unchanged.
- Same-cycle write 0xA5 and read row 9 (old 0x3C) -> doutB = 0x3C; read next cycle -> 0xA5.
- Inject row 7 bit 3 with same-cycle write 0x00 -> subsequent read = 0x08; inject bit >= WIDTH or row >= NUMADDR -> no change.
- Continuous reads to rows 0..15 with SRAM_DELAY=1 and 4 -> doutB sequence in order, vld high every cycle, latency matches parameter.
- Assert rst with 2 reads in flight and ready high -> doutB_vld never pulses for them, doutB = 0, ready low, previously written rows read INITVAL after new sweep.
